// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Shares the single general-register-file write port between two writeback
//   sources: port 0 (in-order pipeline, single-cycle ops) and port 1 (the
//   long-latency divider / load unit). Port 0 normally has priority. Port 1
//   takes priority once it has waited STARVE_LIMIT cycles.
//   A per-register busy scoreboard lets decode stall on operands that port 1
//   still owes. The register-file write is driven from a registered stage,
//   so it appears one cycle after the accept.
//
//   Optional build macro WBARB_PERF_EN adds two 32-bit performance counters:
//   conflict_cnt and starve_cnt.
module gpr_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 64,
  parameter int REG_CNT      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [ADDR_WIDTH-1:0] p0_rd,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p1_rd,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_set_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  reg_wen,
  output logic [ADDR_WIDTH-1:0] reg_rd,
  output logic [DATA_WIDTH-1:0] reg_wdata
`ifdef WBARB_PERF_EN
 ,output logic [31:0]           conflict_cnt,
  output logic [31:0]           starve_cnt
`endif
);

  // The wait counter only has to reach STARVE_LIMIT, which is at most 15.
  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

  // True when idx names a real scoreboard entry other than the hard-wired zero register.
  function automatic logic idx_trackable(input logic [ADDR_WIDTH-1:0] idx);
    logic ok;
    if ((idx != ZERO_IDX) && (32'(idx) < 32'(REG_CNT))) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Reads one busy bit. An out-of-range index reads as not busy.
  function automatic logic busy_read(input logic [REG_CNT-1:0]    vec,
                                     input logic [ADDR_WIDTH-1:0] idx);
    logic b;
    if (32'(idx) < 32'(REG_CNT)) begin
      b = vec[idx];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [REG_CNT-1:0]    busy_q, busy_d;
  logic                  reg_wen_q, reg_wen_d;
  logic [ADDR_WIDTH-1:0] reg_rd_q, reg_rd_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;

  logic starve_s;
  logic acc0_s;
  logic acc1_s;

  // Starvation state comes from the registered wait count, so ready never loops back on itself.
  always_comb begin
    starve_s = (wait_cnt_q == LIMIT_C);
    if (starve_s) begin
      p0_ready = 1'b0;
      p1_ready = 1'b1;
    end else begin
      p0_ready = 1'b1;
      p1_ready = !p0_valid;
    end
    acc0_s = p0_valid && p0_ready;
    acc1_s = p1_valid && p1_ready;
  end

  // Port 1 wait counter: it clears on accept or idle and saturates at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (acc1_s || !p1_valid) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == LIMIT_C) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Write stage select. Index and data hold when nothing is accepted. A write to rd 0 is swallowed.
  always_comb begin
    reg_wen_d   = 1'b0;
    reg_rd_d    = reg_rd_q;
    reg_wdata_d = reg_wdata_q;
    if (acc1_s) begin
      reg_wen_d   = (p1_rd != ZERO_IDX);
      reg_rd_d    = p1_rd;
      reg_wdata_d = p1_wdata;
    end else if (acc0_s) begin
      reg_wen_d   = (p0_rd != ZERO_IDX);
      reg_rd_d    = p0_rd;
      reg_wdata_d = p0_wdata;
    end else begin
      reg_wen_d   = 1'b0;
    end
  end

  // Scoreboard update. Clear happens first, so a same-cycle set of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (acc1_s && idx_trackable(p1_rd)) begin
      busy_d[p1_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (sb_set && idx_trackable(sb_set_rd)) begin
      busy_d[sb_set_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Operand queries read the registered scoreboard. A clear becomes visible when its write lands.
  always_comb begin
    rs1_busy = busy_read(busy_q, rs1);
    rs2_busy = busy_read(busy_q, rs2);
  end

  // State registers. Reset drops all pending work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      busy_q      <= '0;
      reg_wen_q   <= 1'b0;
      reg_rd_q    <= '0;
      reg_wdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      reg_wen_q   <= reg_wen_d;
      reg_rd_q    <= reg_rd_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  assign reg_wen   = reg_wen_q;
  assign reg_rd    = reg_rd_q;
  assign reg_wdata = reg_wdata_q;

`ifdef WBARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] starve_cnt_q, starve_cnt_d;

  // Performance counters: both wrap naturally at 2^32.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    starve_cnt_d   = starve_cnt_q;
    if (p0_valid && p1_valid) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
    if (starve_s && p1_valid) begin
      starve_cnt_d = starve_cnt_q + 32'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= 32'd0;
      starve_cnt_q   <= 32'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign starve_cnt   = starve_cnt_q;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed, table-driven bench for gpr_wb_arbiter (default parameters,
// STARVE_LIMIT = 4). Each vector is held for one clock. Ready and busy are
// checked before the edge, and the write stage is checked just after the edge.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid, sb_set;
  logic        p0_ready, p1_ready, rs1_busy, rs2_busy, reg_wen;
  logic [4:0]  p0_rd, p1_rd, sb_set_rd, rs1, rs2, reg_rd;
  logic [63:0] p0_wdata, p1_wdata, reg_wdata;
`ifdef WBARB_PERF_EN
  logic [31:0] conflict_cnt, starve_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_wdata(p0_wdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_wdata(p1_wdata),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_wen(reg_wen), .reg_rd(reg_rd), .reg_wdata(reg_wdata)
`ifdef WBARB_PERF_EN
   ,.conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt)
`endif
  );

  typedef struct {
    logic        p0v; logic [4:0] p0rd; logic [63:0] p0d;
    logic        p1v; logic [4:0] p1rd; logic [63:0] p1d;
    logic        sbs; logic [4:0] sbrd;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_p0r, e_p1r, e_b1, e_b2;
    logic        e_wen; logic [4:0] e_rd; logic [63:0] e_wd;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
      input logic p0v, input logic [4:0] p0rd, input logic [63:0] p0d,
      input logic p1v, input logic [4:0] p1rd, input logic [63:0] p1d,
      input logic sbs, input logic [4:0] sbrd,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic e_p0r, input logic e_p1r, input logic e_b1, input logic e_b2,
      input logic e_wen, input logic [4:0] e_rd, input logic [63:0] e_wd);
    vec_t v;
    v.p0v = p0v; v.p0rd = p0rd; v.p0d = p0d;
    v.p1v = p1v; v.p1rd = p1rd; v.p1d = p1d;
    v.sbs = sbs; v.sbrd = sbrd; v.r1 = r1; v.r2 = r2;
    v.e_p0r = e_p0r; v.e_p1r = e_p1r; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_wen = e_wen; v.e_rd = e_rd; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p0v, input logic [4:0] p0rd, input logic [63:0] p0d,
                       input logic p1v, input logic [4:0] p1rd, input logic [63:0] p1d,
                       input logic sbs, input logic [4:0] sbrd,
                       input logic [4:0] r1, input logic [4:0] r2);
    p0_valid = p0v; p0_rd = p0rd; p0_wdata = p0d;
    p1_valid = p1v; p1_rd = p1rd; p1_wdata = p1d;
    sb_set = sbs; sb_set_rd = sbrd; rs1 = r1; rs2 = r2;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    //             p0v  p0rd   p0d       p1v  p1rd   p1d         sb  sbrd   rs1    rs2   p0r  p1r  b1   b2   wen  rd     wdata
    vecs[0]  = mk(1'b1, 5'd5, 64'hAA,   1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b1, 5'd5, 64'hAA);
    vecs[1]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd5, 64'hAA);
    vecs[2]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b1, 5'd7, 5'd7, 5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd5, 64'hAA);
    vecs[3]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd7, 5'd5, 1'b1,1'b1,1'b1,1'b0, 1'b0, 5'd5, 64'hAA);
    vecs[4]  = mk(1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'h1234,  1'b0, 5'd0, 5'd7, 5'd0, 1'b1,1'b1,1'b1,1'b0, 1'b1, 5'd7, 64'h1234);
    vecs[5]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd7, 5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd7, 64'h1234);
    vecs[6]  = mk(1'b0, 5'd0, 64'h0,    1'b1, 5'd0, 64'h55,    1'b1, 5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd0, 64'h55);
    vecs[7]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd0, 5'd7, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd0, 64'h55);
    vecs[8]  = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b1, 5'd9, 5'd9, 5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b0, 5'd0, 64'h55);
    vecs[9]  = mk(1'b0, 5'd0, 64'h0,    1'b1, 5'd9, 64'h99,    1'b1, 5'd9, 5'd9, 5'd0, 1'b1,1'b1,1'b1,1'b0, 1'b1, 5'd9, 64'h99);
    vecs[10] = mk(1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd9, 5'd0, 1'b1,1'b1,1'b1,1'b0, 1'b0, 5'd9, 64'h99);
    vecs[11] = mk(1'b1, 5'd0, 64'h77,   1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b1, 1'b0, 5'd0, 64'h77);
    vecs[12] = mk(1'b1, 5'd3, 64'hBB,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b1, 1'b1, 5'd3, 64'hBB);
    vecs[13] = mk(1'b1, 5'd4, 64'hDD,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b1, 1'b1, 5'd4, 64'hDD);
    vecs[14] = mk(1'b1, 5'd5, 64'hEE,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b1, 1'b1, 5'd5, 64'hEE);
    vecs[15] = mk(1'b1, 5'd6, 64'hFF,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b1, 1'b1, 5'd6, 64'hFF);
    vecs[16] = mk(1'b1, 5'd2, 64'h11,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b0,1'b1,1'b0,1'b1, 1'b1, 5'd9, 64'hCC);
    vecs[17] = mk(1'b1, 5'd2, 64'h11,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd9, 1'b1,1'b0,1'b0,1'b0, 1'b1, 5'd2, 64'h11);
    vecs[18] = mk(1'b1, 5'd1, 64'h22,   1'b0, 5'd0, 64'h0,     1'b0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b1, 5'd1, 64'h22);
    vecs[19] = mk(1'b1, 5'd2, 64'h33,   1'b1, 5'd9, 64'hCC,    1'b0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b1, 5'd2, 64'h33);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset reg_wen",   {63'd0, reg_wen},  64'd0);
    chk("reset reg_rd",    {59'd0, reg_rd},   64'd0);
    chk("reset reg_wdata", reg_wdata,         64'd0);
    chk("reset rs1_busy",  {63'd0, rs1_busy}, 64'd0);
    chk("reset p0_ready",  {63'd0, p0_ready}, 64'd1);
    chk("reset p1_ready",  {63'd0, p1_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: each vector is held for one clock
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].p0v, vecs[i].p0rd, vecs[i].p0d, vecs[i].p1v, vecs[i].p1rd, vecs[i].p1d,
            vecs[i].sbs, vecs[i].sbrd, vecs[i].r1, vecs[i].r2);
      @(negedge clk);
      chk($sformatf("v%0d p0_ready", i), {63'd0, p0_ready}, {63'd0, vecs[i].e_p0r});
      chk($sformatf("v%0d p1_ready", i), {63'd0, p1_ready}, {63'd0, vecs[i].e_p1r});
      chk($sformatf("v%0d rs1_busy", i), {63'd0, rs1_busy}, {63'd0, vecs[i].e_b1});
      chk($sformatf("v%0d rs2_busy", i), {63'd0, rs2_busy}, {63'd0, vecs[i].e_b2});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d reg_wen", i),   {63'd0, reg_wen}, {63'd0, vecs[i].e_wen});
      chk($sformatf("v%0d reg_rd", i),    {59'd0, reg_rd},  {59'd0, vecs[i].e_rd});
      chk($sformatf("v%0d reg_wdata", i), reg_wdata,        vecs[i].e_wd);
    end

    // Asynchronous reset in mid-cycle while busy[3]=1 and port 1 has waited 2 cycles
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd8, 64'h33, 1'b1, 5'd3, 64'h44, 1'b0, 5'd0, 5'd3, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre-rst rs1_busy", {63'd0, rs1_busy}, 64'd1);
    chk("pre-rst reg_wen",  {63'd0, reg_wen},  64'd1);
    chk("pre-rst p1_ready", {63'd0, p1_ready}, 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst reg_wen",   {63'd0, reg_wen},  64'd0);
    chk("rst reg_rd",    {59'd0, reg_rd},   64'd0);
    chk("rst reg_wdata", reg_wdata,         64'd0);
    chk("rst rs1_busy",  {63'd0, rs1_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst p1_ready both valid", {63'd0, p1_ready}, 64'd0);
    chk("post-rst p0_ready both valid", {63'd0, p0_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("post-rst p0 write wen", {63'd0, reg_wen}, 64'd1);
    chk("post-rst p0 write rd",  {59'd0, reg_rd},  64'd8);
    drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h44, 1'b0, 5'd0, 5'd3, 5'd0);
    #1;
    chk("post-rst p1_ready p0 idle", {63'd0, p1_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("post-rst p1 write rd",    {59'd0, reg_rd}, 64'd3);
    chk("post-rst p1 write wdata", reg_wdata,       64'h44);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single general-register-file write port between two writeback sources.
  - Port 0: the in-order pipeline writeback, single-cycle ops.
  - Port 1: the long-latency unit (divider / load unit).
- Holds a per-register scoreboard so decode can stall on operands still owed by port 1.
- Drives the register file's write-enable, destination index and write data from a registered stage.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 64, register data width
REG_CNT, 32, number of general registers
STARVE_LIMIT, 4, cycles port 1 may wait before it takes priority (1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
p0_valid  input  1  port 0 writeback request
p0_ready  output  1  port 0 accepted this cycle when valid&&ready
p0_rd  input  ADDR_WIDTH  port 0 destination
p0_wdata  input  DATA_WIDTH  port 0 data
p1_valid  input  1  port 1 writeback request
p1_ready  output  1  port 1 handshake
p1_rd  input  ADDR_WIDTH  port 1 destination
p1_wdata  input  DATA_WIDTH  port 1 data
sb_set  input  1  long-latency op issued this cycle
sb_set_rd  input  ADDR_WIDTH  its destination
rs1  input  ADDR_WIDTH  query index 1
rs2  input  ADDR_WIDTH  query index 2
rs1_busy  output  1  busy[rs1]
rs2_busy  output  1  busy[rs2]
reg_wen  output  1  register file write enable
reg_rd  output  ADDR_WIDTH  register file write index
reg_wdata  output  DATA_WIDTH  register file write data

Behaviour:
- Reset (asynchronous, any cycle, including mid-wait):
  - reg_wen=0, reg_rd=0, reg_wdata=0.
  - busy[] all 0, wait_cnt=0, starve=0.
  - Pending requests are dropped; sources must re-present them.
- Starvation state:
  - starve = (wait_cnt == STARVE_LIMIT), taken from the register value.
- Ready logic (combinational, no dependence on own ready):
  - starve=0: p0_ready=1; p1_ready = !p0_valid.
  - starve=1: p1_ready=1; p0_ready=0.
- Accepts:
  - acc0 = p0_valid && p0_ready; acc1 = p1_valid && p1_ready.
  - At most one accept per cycle by construction.
- wait_cnt:
  - Cleared when acc1 or !p1_valid.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Write stage (latency 1, registered):
  - reg_wen <= (acc0 || acc1) && selected rd != 0.
  - reg_rd / reg_wdata <= the selected port's rd/data.
  - reg_rd / reg_wdata hold their previous value when nothing is accepted.
  - A request with rd=0 is accepted but never writes.
- Scoreboard:
  - sb_set && sb_set_rd!=0 sets busy[sb_set_rd].
  - acc1 clears busy[p1_rd].
  - Same index set and cleared in one cycle: set wins (a new producer is pending).
  - busy[0] is always 0.
- Query outputs:
  - rsN_busy = busy[rsN] from the register, combinational read.
  - A register cleared this cycle reads busy until the next edge; its data lands in the register file on that edge.
- Port 0 does not touch the scoreboard.

Optional Feature:
- Macro: WBARB_PERF_EN.
- Defined:
  - Adds output conflict_cnt, 32 bits, reset 0.
  - Increments each cycle p0_valid && p1_valid, wrapping at 2^32.
  - Adds output starve_cnt, 32 bits, reset 0.
  - Increments each cycle starve=1 && p1_valid.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Only p0_valid=1, rd=5, data=0xAA for one cycle -> p0_ready=1; next cycle reg_wen=1, reg_rd=5, reg_wdata=0xAA; following cycle reg_wen=0.
- sb_set rd=7, then rs1=7 -> rs1_busy=1. Then p1_valid=1, rd=7, data=0x1234 with p0 idle -> p1_ready=1, reg_wen=1 / reg_rd=7 one cycle later, and rs1_busy=0 the same cycle as reg_wen.
- p0_valid and p1_valid held high continuously, STARVE_LIMIT=4 -> p1_ready=0 for 4 cycles, 1 on the 5th cycle with p0_ready=0 that cycle; wait_cnt back to 0 after the accept.
- p1 write with rd=0 and sb_set rd=0 -> p1 accepted, reg_wen stays 0, rs1_busy(rs1=0)=0.
- sb_set rd=9 in the same cycle as p1 accept rd=9 -> busy[9] remains 1 afterwards; write to 9 still issued.
- rst asserted mid-cycle while busy[3]=1 and wait_cnt=2 -> immediately reg_wen=0, rs1_busy(3)=0; after release p1 accepted only when p0 idle.
